dvf_rst_seq_ctrl: RTL and testbench
===================================

# dvf_rst_seq_ctrl

Reset sequencer and arbiter for a downstream clock/reset domain. It shares one domain reset output between NUM_REQ reset requesters using round-robin arbitration. Each granted request runs a programmable pre-delay, reset-assert and post-delay sequence measured in clocks, then acknowledges the requester. After its own reset it also performs an automatic power-on reset of the domain.

## Interface
Parameters:
- NUM_REQ, 3, number of reset requesters (≥2)
- CNT_W, 8, width of the phase-length config fields and the internal counter
- DEF_WIDTH, 16, power-on reset assert length in clocks (1..2^CNT_W-1)
- DEF_POST, 4, power-on post-delay in clocks (0..2^CNT_W-1)

Ports:
- clk  in  1  sequencer clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  level reset requests; requester holds high until its ack
- ack  out  NUM_REQ  one-cycle completion pulse, one-hot
- cfg_pre_clks  in  CNT_W  clocks before assertion; 0 skips PRE
- cfg_width_clks  in  CNT_W  clocks rst_out is held; 0 is treated as 1
- cfg_post_clks  in  CNT_W  clocks after release; 0 skips POST
- rst_out  out  1  active-high domain reset, registered
- busy  out  1  high in every state except IDLE
- state_o  out  3  IDLE=0, PRE=1, ASSERT=2, POST=3, DONE=4, POR=5
- grant_src  out  $clog2(NUM_REQ)  index of the requester being served

## Operation
- States: POR, IDLE, PRE, ASSERT, POST, DONE. All outputs are derived from registered state, the counter and the source register.
- While rst is high:
  - state=POR, counter loaded with DEF_WIDTH
  - rst_out=1, ack=0, busy=1, grant_src=0
  - round-robin pointer=0
- POR: rst_out=1 for DEF_WIDTH cycles after rst falls, then POST for DEF_POST cycles (skipped if 0), then IDLE. No ack is pulsed.
- IDLE: if any req bit is high, pick the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Latch grant_src and all three cfg fields. Changes to cfg during the sequence are ignored.
  - Set pointer = winner+1, mod NUM_REQ.
  - Go to PRE (counter=pre) if pre≠0, else ASSERT (counter=max(width,1)).
- PRE: counter counts down; when it reaches 1, go to ASSERT.
- ASSERT: rst_out=1; counter counts down; when it reaches 1, go to POST, or to DONE if post=0.
- POST: counter counts down; when it reaches 1, go to DONE.
- DONE: ack[grant_src]=1 for exactly one cycle, then IDLE.
- Requests raised while busy stay pending (level) and are arbitrated in the next IDLE cycle.
- A req still high in the cycle after its ack starts a new sequence. Requesters must drop req in the ack cycle.
- Simultaneous requests: the pointer decides; the others wait their turn. There is no starvation (round-robin).
- rst asserted mid-sequence: immediate return to POR. Any pending ack is lost and the requester must keep req high, so it is served after POR.

## Timing
- Request high in cycle T (IDLE) with latched P, W'=max(W,1), Q:
  - PRE: cycles T+1..T+P
  - ASSERT (rst_out=1): cycles T+P+1..T+P+W'
  - POST: cycles T+P+W'+1..T+P+W'+Q
  - DONE (ack): cycle T+P+W'+Q+1
- busy is high from T+1 through the ack cycle, then low for at least one IDLE cycle.
- Back-to-back sequences therefore have a minimum 1-cycle IDLE gap. The minimum total sequence is 3 cycles (P=0, W=0, Q=0: ASSERT, DONE, IDLE).
- rst_out rises and falls only on clk edges, except the asynchronous rise caused by rst.
- Counter width is CNT_W and has no wrap. The maximum phase is 2^CNT_W-1 clocks.

## Test plan
- Power-on: rst high for 3 cycles, then low, with DEF_WIDTH=16 and DEF_POST=4. Expect:
  - rst_out=1 for 16 cycles after release
  - busy for 20 cycles
  - IDLE in the 21st cycle, with no ack.
- Single request: P=2, W=3, Q=1, req[0] high in cycle 0. Expect:
  - PRE in cycles 1-2
  - rst_out=1 in cycles 3-5, POST in cycle 6
  - ack[0] pulse in cycle 7, busy low in cycle 8.
- Zero lengths: P=0, W=0, Q=0, req[1] in cycle 0. Expect rst_out=1 in cycle 1 only and ack[1] in cycle 2.
- Round-robin: req[0], req[1] and req[2] all held high from the same cycle, each dropped on its own ack. Expect grants in order 0, 1, 2. Then raise req[0] and req[2] together: expect 0, then 2.
- Config stability: change cfg_width_clks from 3 to 9 during PRE. Expect rst_out held for exactly 3 cycles.
- Mid-sequence reset: pulse rst during ASSERT of a req[2] sequence. Expect:
  - rst_out stays 1, no ack[2]
  - a POR sequence runs
  - req[2], still high, is served with ack[2] after POR completes.

Source files
------------

// File: rtl/dvf_rst_seq_ctrl.sv
// Reset sequencer for a downstream domain: power-on reset, then round-robin
// service of reset requesters with programmable pre/assert/post phases.
module dvf_rst_seq_ctrl #(
  parameter int NUM_REQ   = 3,
  parameter int CNT_W     = 8,
  parameter int DEF_WIDTH = 16,
  parameter int DEF_POST  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         ack,
  input  logic [CNT_W-1:0]           cfg_pre_clks,
  input  logic [CNT_W-1:0]           cfg_width_clks,
  input  logic [CNT_W-1:0]           cfg_post_clks,
  output logic                       rst_out,
  output logic                       busy,
  output logic [2:0]                 state_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_src
);

  localparam int SW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE    = 3'd1,
    ASSERT = 3'd2,
    POST   = 3'd3,
    DONE   = 3'd4,
    POR    = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] wid, wid_n;
  logic [CNT_W-1:0] post, post_n;
  logic [SW-1:0]    src, src_n;
  logic [SW-1:0]    ptr, ptr_n;
  logic             por_run, por_n;

  logic             found;
  logic [SW-1:0]    win;
  logic [SW-1:0]    jj;
  logic [SW-1:0]    win_nxt;
  logic [CNT_W-1:0] wid_eff;
  logic             last;
  int               j;

  // first set request at or after the pointer, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    jj    = '0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = SW'(j);
      if (!found && req[jj]) begin
        found = 1'b1;
        win   = jj;
      end
    end
  end

  assign win_nxt = (win == SW'(NUM_REQ-1)) ? '0 : win + 1'b1;
  assign wid_eff = (cfg_width_clks == '0) ? CNT_W'(1) : cfg_width_clks;
  assign last    = (cnt <= CNT_W'(1));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wid_n   = wid;
    post_n  = post;
    src_n   = src;
    ptr_n   = ptr;
    por_n   = por_run;
    unique case (state)
      POR: begin
        if (!last) begin
          cnt_n = cnt - 1'b1;
        end else if (DEF_POST != 0) begin
          state_n = POST;
          cnt_n   = CNT_W'(DEF_POST);
        end else begin
          state_n = IDLE;
          por_n   = 1'b0;
        end
      end
      IDLE: begin
        if (found) begin
          src_n  = win;
          ptr_n  = win_nxt;
          wid_n  = wid_eff;
          post_n = cfg_post_clks;
          if (cfg_pre_clks != '0) begin
            state_n = PRE;
            cnt_n   = cfg_pre_clks;
          end else begin
            state_n = ASSERT;
            cnt_n   = wid_eff;
          end
        end
      end
      PRE: begin
        if (!last) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = ASSERT;
          cnt_n   = wid;
        end
      end
      ASSERT: begin
        if (!last) begin
          cnt_n = cnt - 1'b1;
        end else if (post != '0) begin
          state_n = POST;
          cnt_n   = post;
        end else begin
          state_n = DONE;
        end
      end
      POST: begin
        if (!last) begin
          cnt_n = cnt - 1'b1;
        end else if (por_run) begin
          // power-on post-delay ends without an ack
          state_n = IDLE;
          por_n   = 1'b0;
        end else begin
          state_n = DONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= POR;
      cnt     <= CNT_W'(DEF_WIDTH);
      wid     <= '0;
      post    <= '0;
      src     <= '0;
      ptr     <= '0;
      por_run <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      wid     <= wid_n;
      post    <= post_n;
      src     <= src_n;
      ptr     <= ptr_n;
      por_run <= por_n;
    end
  end

  assign rst_out   = (state == ASSERT) || (state == POR);
  assign busy      = (state != IDLE);
  assign state_o   = state;
  assign grant_src = src;
  assign ack       = (state == DONE) ? (NUM_REQ'(1) << src) : '0;

endmodule

// File: tb/tb_dvf_rst_seq_ctrl.sv
// Directed bench for dvf_rst_seq_ctrl: vector table of single requests plus
// power-on, round-robin, config-stability and mid-sequence reset sequences.
module tb_dvf_rst_seq_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic [2:0] ack;
  logic [7:0] cfg_pre_clks;
  logic [7:0] cfg_width_clks;
  logic [7:0] cfg_post_clks;
  logic       rst_out;
  logic       busy;
  logic [2:0] state_o;
  logic [1:0] grant_src;

  int n_vec = 0;
  int n_bad = 0;

  dvf_rst_seq_ctrl #(
    .NUM_REQ(3), .CNT_W(8), .DEF_WIDTH(16), .DEF_POST(4)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .cfg_pre_clks(cfg_pre_clks),
    .cfg_width_clks(cfg_width_clks),
    .cfg_post_clks(cfg_post_clks),
    .rst_out(rst_out), .busy(busy),
    .state_o(state_o), .grant_src(grant_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int idx;
    int p;
    int w;
    int q;
    int a_first;
    int a_last;
    int ack_c;
    int st1;
  } vec_t;

  vec_t tv[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 1000; n++) begin
      if (busy === 1'b0) return;
      tick();
    end
    chk("wait_idle_timeout", 32'(busy), 0);
  endtask

  initial begin
    int ack_k;
    int nr;
    int k;
    logic [2:0] got;
    int rr_exp[5];

    tv[0] = '{0, 2, 3, 1, 3, 5, 7, 1};
    tv[1] = '{1, 0, 0, 0, 1, 1, 2, 2};
    tv[2] = '{2, 1, 1, 0, 2, 2, 3, 1};
    tv[3] = '{0, 0, 4, 2, 1, 4, 7, 2};
    tv[4] = '{1, 3, 0, 3, 4, 4, 8, 1};
    tv[5] = '{2, 0, 255, 0, 1, 255, 256, 2};

    rst = 1'b1;
    req = '0;
    cfg_pre_clks = '0;
    cfg_width_clks = '0;
    cfg_post_clks = '0;

    // power-on
    repeat (3) tick();
    chk("rst_state", 32'(state_o), 5);
    chk("rst_rst_out", 32'(rst_out), 1);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_grant", 32'(grant_src), 0);
    rst = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      chk("por_rst_out", 32'(rst_out), (c <= 16) ? 1 : 0);
      chk("por_busy", 32'(busy), (c <= 20) ? 1 : 0);
      chk("por_ack", 32'(ack), 0);
      chk("por_state", 32'(state_o),
          (c <= 16) ? 5 : ((c <= 20) ? 3 : 0));
      if (c < 21) tick();
    end

    // table of single requests
    for (int v = 0; v < 6; v++) begin
      wait_idle();
      cfg_pre_clks = 8'(tv[v].p);
      cfg_width_clks = 8'(tv[v].w);
      cfg_post_clks = 8'(tv[v].q);
      req = 3'(1 << tv[v].idx);
      for (int c = 1; c <= tv[v].ack_c + 1; c++) begin
        tick();
        chk("vec_rst_out", 32'(rst_out),
            (c >= tv[v].a_first && c <= tv[v].a_last) ? 1 : 0);
        chk("vec_ack", 32'(ack),
            (c == tv[v].ack_c) ? (1 << tv[v].idx) : 0);
        chk("vec_busy", 32'(busy), (c <= tv[v].ack_c) ? 1 : 0);
        if (c == 1) begin
          chk("vec_state1", 32'(state_o), tv[v].st1);
          chk("vec_grant", 32'(grant_src), tv[v].idx);
        end
        if (c == tv[v].ack_c) req = '0;
      end
    end

    // round-robin: all three, then 0 and 2
    rr_exp = '{0, 1, 2, 0, 2};
    wait_idle();
    cfg_pre_clks = '0;
    cfg_width_clks = '0;
    cfg_post_clks = '0;
    nr = 0;
    req = 3'b111;
    for (int c = 0; c < 60 && nr < 5; c++) begin
      tick();
      if (ack != '0) begin
        chk("rr_order", 32'(ack), 1 << rr_exp[nr]);
        req = req & ~ack;
        nr++;
        if (nr == 3) begin
          tick();
          req = 3'b101;
        end
      end
    end
    chk("rr_count", nr, 5);
    req = '0;

    // config change during PRE is ignored
    wait_idle();
    cfg_pre_clks = 8'd2;
    cfg_width_clks = 8'd3;
    cfg_post_clks = 8'd0;
    req = 3'b001;
    nr = 0;
    ack_k = 0;
    for (int c = 1; c <= 30 && ack_k == 0; c++) begin
      tick();
      if (c == 1) cfg_width_clks = 8'd9;
      if (rst_out === 1'b1) nr++;
      if (ack != '0) begin
        ack_k = c;
        got = ack;
        req = '0;
      end
    end
    chk("cfg_width_held", nr, 3);
    chk("cfg_ack_cycle", ack_k, 6);
    chk("cfg_ack_val", 32'(got), 1);

    // reset in the middle of ASSERT
    wait_idle();
    cfg_pre_clks = 8'd0;
    cfg_width_clks = 8'd5;
    cfg_post_clks = 8'd0;
    req = 3'b100;
    tick();
    tick();
    chk("mid_assert", 32'(state_o), 2);
    rst = 1'b1;
    #1;
    chk("mid_async_state", 32'(state_o), 5);
    chk("mid_async_rst_out", 32'(rst_out), 1);
    chk("mid_ack", 32'(ack), 0);
    tick();
    rst = 1'b0;
    k = 1;
    ack_k = 0;
    got = '0;
    while (k <= 40 && ack_k == 0) begin
      if (k == 1) chk("mid_por_state", 32'(state_o), 5);
      if (k == 21) chk("mid_idle_busy", 32'(busy), 0);
      if (k == 22) chk("mid_reserve", 32'(state_o), 2);
      if (ack != '0) begin
        ack_k = k;
        got = ack;
        req = '0;
      end else begin
        tick();
        k++;
      end
    end
    chk("mid_ack_cycle", ack_k, 27);
    chk("mid_ack_val", 32'(got), 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
